apb_slave_regs: RTL and testbench
=================================

# apb_slave_regs

APB completer that terminates transfers issued by the team's APB master: a bank of 32-bit registers with a programmable number of wait states, error response on bad addresses, and completed-transfer counters. It sits directly downstream of the master on the APB bus. It samples the address, direction and write data in the access phase, drives `pready`, `prdata` and `pslverr` back, and commits writes on the completing edge.

## Interface
- `NUM_REGS`, 16: number of 32-bit registers, 2..256; register 0 is a read-only ID register.
- `BASE_ADDR`, 32'hA000: byte address of register 0; must be 4-byte aligned.
- `WAIT_STATES`, 2: access-phase cycles with `pready`=0 before completion, 0..15.
- `ID_VALUE`, 32'h5A5A_0016: value returned by register 0.

Ports:
- `pclk` input 1: clock; everything is on the rising edge.
- `preset` input 1: synchronous, active-high reset.
- `psel` input 1: APB select.
- `penable` input 1: APB access phase.
- `paddr` input 32: byte address; sampled only in the access phase.
- `pwrite` input 1: 1 = write, 0 = read.
- `pwdata` input 32: write data.
- `pready` output 1: transfer completes this cycle.
- `prdata` output 32: read data; valid only when `pready` and `!pwrite`, otherwise 0.
- `pslverr` output 1: error response; valid only with `pready`, otherwise 0.
- `wr_count` output 16: number of successful writes, wrapping.
- `rd_count` output 16: number of successful reads, wrapping.

## Operation
- Decode: `off = paddr - BASE_ADDR`, `idx = off[31:2]`.
  - Valid when `paddr[1:0]==0` and `idx < NUM_REGS`.
  - A write to `idx==0` is an error; a read of `idx==0` returns `ID_VALUE`.
  - Any invalid address is an error. An error completes with `pslverr`=1; no register changes, `prdata`=0 and no counter increments.
- Register bank: `NUM_REGS-1` writable registers at indices 1..NUM_REGS-1. Reset value is 0.
- FSM, two states:
  - IDLE to WAIT when `psel & penable & !pready`.
  - WAIT to IDLE on `pready`, or on `!psel | !penable`.
  - In IDLE, `psel & penable` with `WAIT_STATES==0` completes in the same cycle.
- Wait counter `wcnt` (4 bits):
  - Increments on every access-phase cycle where `pready`=0.
  - Cleared in IDLE, on completion, and on abort.
  - `pready = psel & penable & (wcnt == WAIT_STATES)`, which is combinational from state and inputs.
- Write commit: on the rising edge that ends a `pready`=1 write cycle with no error, `reg[idx] <= pwdata` and `wr_count` increments.
- Read: `prdata = reg[idx]`, or `ID_VALUE` for register 0, during the `pready` cycle. `rd_count` increments on that edge.
- Counters wrap from 16'hFFFF to 16'h0000.
- Setup phase (`psel`=1, `penable`=0): ignored. `paddr` may be 0 in this phase; it is never decoded.
- Abort: if `psel` or `penable` deasserts before `pready`, the transfer is dropped. `wcnt` clears, the FSM returns to IDLE, nothing is written and nothing is counted.
- Reset asserted mid-transfer: on that edge all registers, counters, `wcnt` and the FSM return to reset state. `pready`, `prdata` and `pslverr` are 0 while `preset`=1.

## Timing
- Reset values: `pready`=0, `prdata`=0, `pslverr`=0, `wr_count`=0, `rd_count`=0, FSM=IDLE, registers=0.
- Transfer latency:
  - Setup cycle T0.
  - First access cycle T1.
  - `pready`=1 in cycle T1+WAIT_STATES.
  - A write is visible to a read whose access phase starts on the next edge or later.
- Back-to-back: a new setup phase may start in the cycle after `pready`. No idle cycle is required; the FSM is in IDLE with `wcnt`=0.
- `paddr`, `pwrite` and `pwdata` are decoded combinationally in every access cycle. The master holds them stable through the access phase.
- Error and normal completions have identical latency.

## Test plan
- Reset: hold `preset`=1 for 2 cycles → all outputs 0; read of `BASE_ADDR+4` returns 0.
- Write then read, `WAIT_STATES`=2: write 32'hDEADBEEF to 32'hA004 → `pready` goes high exactly 2 cycles after the first access cycle, `pslverr`=0, `wr_count`=1. Read 32'hA004 → `prdata`=32'hDEADBEEF, `rd_count`=1.
- ID and errors:
  - Read 32'hA000 → `prdata`=32'h5A5A_0016.
  - Write 32'hA000 → `pslverr`=1, register 0 unchanged.
  - Read 32'hA040 (idx 16) → `pslverr`=1.
  - Read 32'hA002 (misaligned) → `pslverr`=1.
  - `rd_count` and `wr_count` unchanged by all error transfers.
- `WAIT_STATES`=0 back-to-back: writes to 32'hA008 then 32'hA00C in consecutive setup/access pairs → `pready`=1 in each access cycle, both registers updated, `wr_count`=2.
- Abort and reset mid-transfer:
  - Drop `penable` in the first WAIT cycle of a write to 32'hA010 → register unchanged, `wr_count` unchanged, next transfer has full latency.
  - Assert `preset` during a WAIT cycle → all outputs 0 on the next cycle.
- Counter wrap: preload by issuing 65535 successful writes, then one more → `wr_count` goes 16'hFFFF to 16'h0000.

Source files
------------

// File: rtl/apb_slave_regs.sv
// APB completer: bank of 32-bit registers with an ID register at index 0,
// programmable wait states, error response on bad addresses and transfer counters.
module apb_slave_regs #(
  parameter int          NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'hA000,
  parameter int          WAIT_STATES = 2,
  parameter logic [31:0] ID_VALUE    = 32'h5A5A_0016
) (
  input  logic        pclk,
  input  logic        preset,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] paddr,
  input  logic        pwrite,
  input  logic [31:0] pwdata,
  output logic        pready,
  output logic [31:0] prdata,
  output logic        pslverr,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count
);

  localparam int IW = $clog2(NUM_REGS);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] wr_count_q, wr_count_d;
  logic [15:0] rd_count_q, rd_count_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [29:0]   idx;
  logic [IW-1:0] idx_w;
  logic          addr_ok;
  logic          err;
  logic          access;
  logic          commit_wr;
  logic          commit_rd;

  // Addresses below BASE_ADDR wrap to a huge index and fail the range check.
  always_comb begin
    idx       = 30'((paddr - BASE_ADDR) >> 2);
    idx_w     = idx[IW-1:0];
    addr_ok   = (paddr[1:0] == 2'b00) && ({2'b00, idx} < 32'(NUM_REGS));
    err       = !addr_ok || (pwrite && (idx == 30'd0));
    access    = psel && penable && !preset;
    pready    = access && (wcnt_q == 4'(WAIT_STATES));
    pslverr   = pready && err;
    commit_wr = pready && pwrite && !err;
    commit_rd = pready && !pwrite && !err;
    prdata    = '0;
    if (commit_rd) begin
      prdata = (idx == 30'd0) ? ID_VALUE : regs_q[idx_w];
    end
  end

  always_comb begin
    state_d    = state_q;
    wcnt_d     = '0;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    regs_d     = regs_q;
    if (access && !pready) begin
      wcnt_d = wcnt_q + 4'd1;
    end
    case (state_q)
      S_IDLE: if (access && !pready) state_d = S_WAIT;
      S_WAIT: if (pready || !access) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (commit_wr) begin
      regs_d[idx_w] = pwdata;
      wr_count_d    = wr_count_q + 16'd1;
    end
    if (commit_rd) begin
      rd_count_d = rd_count_q + 16'd1;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      regs_q     <= regs_d;
    end
  end

  assign wr_count = wr_count_q;
  assign rd_count = rd_count_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench for apb_slave_regs: one instance with two wait states,
// one with zero wait states, both checked against an address-map reference model.
module tb_apb_slave_regs;

  localparam int          NUM  = 16;
  localparam logic [31:0] BASE = 32'hA000;
  localparam logic [31:0] ID   = 32'h5A5A_0016;
  localparam int          WS   = 2;

  logic        pclk;
  logic        preset;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic        pready, pslverr;
  logic [31:0] prdata;
  logic [15:0] wr_count, rd_count;

  logic        psel0, penable0, pwrite0;
  logic [31:0] paddr0, pwdata0;
  logic        pready0, pslverr0;
  logic [31:0] prdata0;
  logic [15:0] wr_count0, rd_count0;

  logic [31:0] model [NUM];
  logic [15:0] modelWr, modelRd;
  int          checks, errors;

  apb_slave_regs #(.NUM_REGS(NUM), .BASE_ADDR(BASE), .WAIT_STATES(WS), .ID_VALUE(ID)) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .paddr(paddr),
    .pwrite(pwrite), .pwdata(pwdata), .pready(pready), .prdata(prdata),
    .pslverr(pslverr), .wr_count(wr_count), .rd_count(rd_count)
  );

  apb_slave_regs #(.NUM_REGS(NUM), .BASE_ADDR(BASE), .WAIT_STATES(0), .ID_VALUE(ID)) dut0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable0), .paddr(paddr0),
    .pwrite(pwrite0), .pwdata(pwdata0), .pready(pready0), .prdata(prdata0),
    .pslverr(pslverr0), .wr_count(wr_count0), .rd_count(rd_count0)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic isErr(input logic wr, input logic [31:0] addr);
    logic [31:0] off;
    off = addr - BASE;
    if (addr[1:0] != 2'b00) return 1'b1;
    if ((off / 4) >= NUM) return 1'b1;
    if (wr && (off / 4) == 0) return 1'b1;
    return 1'b0;
  endfunction

  // Full setup + access transfer on the two-wait-state instance.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input string tag);
    logic        e;
    logic [31:0] expRd;
    int          ix;
    e     = isErr(wr, addr);
    ix    = int'((addr - BASE) >> 2);
    expRd = 32'h0;
    if (!e && !wr) expRd = (ix == 0) ? ID : model[ix];
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = 32'h0; pwdata = data;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = addr;
    for (int k = 0; k <= WS; k++) begin
      @(negedge pclk);
      checkOutput($sformatf("%s_rdy%0d", tag, k), 32'(pready), 32'(k == WS));
    end
    checkOutput({tag, "_err"}, 32'(pslverr), 32'(e));
    checkOutput({tag, "_rdata"}, prdata, expRd);
    @(posedge pclk);
    if (!e) begin
      if (wr) begin
        model[ix] = data;
        modelWr++;
      end else begin
        modelRd++;
      end
    end
    #1;
    psel = 1'b0; penable = 1'b0; paddr = 32'h0;
    @(negedge pclk);
    checkOutput({tag, "_wrcnt"}, 32'(wr_count), 32'(modelWr));
    checkOutput({tag, "_rdcnt"}, 32'(rd_count), 32'(modelRd));
  endtask

  initial begin
    logic        w;
    logic [31:0] a;
    logic [15:0] expWr0;
    checks = 0; errors = 0;
    modelWr = '0; modelRd = '0;
    for (int i = 0; i < NUM; i++) model[i] = '0;
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
    psel0 = 0; penable0 = 0; pwrite0 = 0; paddr0 = 0; pwdata0 = 0;

    // Reset with an access phase presented to the zero-wait instance.
    preset = 1'b1;
    psel0 = 1'b1; penable0 = 1'b1; pwrite0 = 1'b0; paddr0 = BASE;
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    checkOutput("rst_pready0", 32'(pready0), 32'h0);
    checkOutput("rst_prdata0", prdata0, 32'h0);
    checkOutput("rst_pslverr0", 32'(pslverr0), 32'h0);
    checkOutput("rst_pready", 32'(pready), 32'h0);
    checkOutput("rst_wrcnt", 32'(wr_count), 32'h0);
    checkOutput("rst_rdcnt", 32'(rd_count), 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0; psel0 = 1'b0; penable0 = 1'b0; paddr0 = 32'h0;

    applyStimulus(1'b0, BASE + 4, 32'h0, "rd_a004_rst");
    applyStimulus(1'b1, 32'hA004, 32'hDEAD_BEEF, "wr_a004");
    applyStimulus(1'b0, 32'hA004, 32'h0, "rd_a004");
    applyStimulus(1'b0, 32'hA000, 32'h0, "rd_id");
    applyStimulus(1'b1, 32'hA000, 32'h1234_5678, "wr_id");
    applyStimulus(1'b0, 32'hA000, 32'h0, "rd_id2");
    applyStimulus(1'b0, 32'hA040, 32'h0, "rd_oob");
    applyStimulus(1'b0, 32'hA002, 32'h0, "rd_mis");
    applyStimulus(1'b1, 32'hA03C, 32'h0BAD_F00D, "wr_last");
    applyStimulus(1'b1, 32'h9FFC, 32'h0BAD_F00D, "wr_below");

    // Abort: penable drops in the first wait cycle of a write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h1357_9BDF;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = 32'hA010;
    @(negedge pclk);
    checkOutput("abort_rdy_t1", 32'(pready), 32'h0);
    @(posedge pclk); #1;
    penable = 1'b0;
    @(negedge pclk);
    checkOutput("abort_rdy_t2", 32'(pready), 32'h0);
    @(posedge pclk); #1;
    psel = 1'b0; paddr = 32'h0;
    @(negedge pclk);
    checkOutput("abort_wrcnt", 32'(wr_count), 32'(modelWr));
    applyStimulus(1'b0, 32'hA010, 32'h0, "rd_after_abort");

    for (int n = 0; n < 40; n++) begin
      w = 1'($urandom_range(0, 1));
      a = BASE + 32'($urandom_range(0, NUM + 2)) * 4;
      if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
      if ($urandom_range(0, 9) == 0) a = BASE - 4;
      applyStimulus(w, a, $urandom, $sformatf("rnd%0d", n));
    end

    // Reset arrives in the wait cycle where pready would otherwise rise.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'hFACE_0008;
    @(posedge pclk); #1;
    penable = 1'b1; paddr = 32'hA008;
    repeat (WS) @(posedge pclk);
    #1 preset = 1'b1;
    @(negedge pclk);
    checkOutput("midrst_pready", 32'(pready), 32'h0);
    checkOutput("midrst_pslverr", 32'(pslverr), 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0; psel = 1'b0; penable = 1'b0; paddr = 32'h0;
    for (int i = 0; i < NUM; i++) model[i] = '0;
    modelWr = '0; modelRd = '0;
    @(negedge pclk);
    checkOutput("midrst_wrcnt", 32'(wr_count), 32'h0);
    checkOutput("midrst_rdcnt", 32'(rd_count), 32'h0);
    checkOutput("midrst_pready2", 32'(pready), 32'h0);
    applyStimulus(1'b0, 32'hA004, 32'h0, "rd_a004_after_rst");
    applyStimulus(1'b0, 32'hA008, 32'h0, "rd_a008_after_rst");

    // Zero wait states, back-to-back writes with no idle cycle.
    @(posedge pclk); #1;
    psel0 = 1'b1; penable0 = 1'b0; pwrite0 = 1'b1; paddr0 = 32'h0; pwdata0 = 32'h1111_0008;
    @(posedge pclk); #1;
    penable0 = 1'b1; paddr0 = 32'hA008;
    @(negedge pclk);
    checkOutput("b2b_rdy1", 32'(pready0), 32'h1);
    checkOutput("b2b_err1", 32'(pslverr0), 32'h0);
    @(posedge pclk); #1;
    penable0 = 1'b0; paddr0 = 32'h0; pwdata0 = 32'h2222_000C;
    @(negedge pclk);
    checkOutput("b2b_setup_rdy", 32'(pready0), 32'h0);
    @(posedge pclk); #1;
    penable0 = 1'b1; paddr0 = 32'hA00C;
    @(negedge pclk);
    checkOutput("b2b_rdy2", 32'(pready0), 32'h1);
    @(posedge pclk); #1;
    psel0 = 1'b0; penable0 = 1'b0; paddr0 = 32'h0;
    @(negedge pclk);
    checkOutput("b2b_wrcnt", 32'(wr_count0), 32'h2);
    for (int j = 0; j < 2; j++) begin
      @(posedge pclk); #1;
      psel0 = 1'b1; penable0 = 1'b0; pwrite0 = 1'b0; paddr0 = 32'h0;
      @(posedge pclk); #1;
      penable0 = 1'b1; paddr0 = (j == 0) ? 32'hA008 : 32'hA00C;
      @(negedge pclk);
      checkOutput($sformatf("b2b_rd%0d_rdy", j), 32'(pready0), 32'h1);
      checkOutput($sformatf("b2b_rd%0d_data", j), prdata0, (j == 0) ? 32'h1111_0008 : 32'h2222_000C);
    end
    @(posedge pclk); #1;
    psel0 = 1'b0; penable0 = 1'b0; paddr0 = 32'h0;
    @(negedge pclk);
    checkOutput("b2b_rdcnt", 32'(rd_count0), 32'h2);

    // Counter wrap: hold a zero-wait write access so every edge commits one write.
    expWr0 = 16'd2;
    @(posedge pclk); #1;
    psel0 = 1'b1; penable0 = 1'b0; pwrite0 = 1'b1; pwdata0 = 32'hC0FF_EE14;
    @(posedge pclk); #1;
    penable0 = 1'b1; paddr0 = 32'hA014;
    repeat (65533) @(posedge pclk);
    expWr0 = expWr0 + 16'd65533;
    @(negedge pclk);
    checkOutput("wrap_ffff", 32'(wr_count0), 32'(expWr0));
    @(posedge pclk);
    expWr0 = expWr0 + 16'd1;
    #1 psel0 = 1'b0; penable0 = 1'b0; paddr0 = 32'h0;
    @(negedge pclk);
    checkOutput("wrap_zero", 32'(wr_count0), 32'(expWr0));
    checkOutput("wrap_rdcnt", 32'(rd_count0), 32'h2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
